// File: rtl/angle_quartor_reducer.sv
// Pre-CORDIC argument reducer: folds a signed angle modulo 2*pi into [0, pi/2)
// and reports the quadrant code consumed by the output quadrant rotator.
module angle_quartor_reducer #(
  parameter int ANGLE_WIDTH = 24,
  parameter int DATA_WIDTH  = 20,
  parameter int FRAC_BITS   = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   rst_step,
  input  logic                   new_data,
  input  logic [ANGLE_WIDTH-1:0] angle_i,
  output logic [DATA_WIDTH-1:0]  angle_o,
  output logic [1:0]             quartor,
  output logic                   data_ready,
  output logic                   busy
);

  localparam int J  = ANGLE_WIDTH - FRAC_BITS;
  localparam int RW = ANGLE_WIDTH + 3;
  localparam int JW = $clog2(J + 1);

  // round(pi/2 * 2^16); every C0 << j with j >= 2 is a whole number of turns
  localparam logic [RW-1:0] C0 = RW'(102944);
  localparam logic [RW-1:0] CJ = C0 << J;

  typedef enum logic [1:0] {
    IDLE,
    NORM,
    REDUCE
  } state_t;

  state_t                state_q, state_d;
  logic [RW-1:0]         r_q, r_d;
  logic [JW-1:0]         j_q, j_d;
  logic                  b1_q, b1_d;
  logic [DATA_WIDTH-1:0] angle_q, angle_d;
  logic [1:0]            quartor_q, quartor_d;
  logic                  ready_q, ready_d;
  logic                  busy_q, busy_d;
  logic [RW-1:0]         c_j;
  logic                  take;

  always_comb begin
    state_d   = state_q;
    r_d       = r_q;
    j_d       = j_q;
    b1_d      = b1_q;
    angle_d   = angle_q;
    quartor_d = quartor_q;
    ready_d   = ready_q;
    busy_d    = busy_q;
    c_j       = C0 << j_q;
    take      = (r_q >= c_j);

    unique case (state_q)
      IDLE: begin
        if (new_data) begin
          r_d     = {{3{angle_i[ANGLE_WIDTH-1]}}, angle_i};
          ready_d = 1'b0;
          busy_d  = 1'b1;
          state_d = NORM;
        end
      end
      NORM: begin
        // Negative remainders are lifted by a whole number of turns first
        if (r_q[RW-1]) begin
          r_d = r_q + CJ;
        end
        j_d     = JW'(J);
        state_d = REDUCE;
      end
      REDUCE: begin
        if (take) begin
          r_d = r_q - c_j;
        end
        if (j_q == JW'(1)) begin
          b1_d = take;
        end
        if (j_q == '0) begin
          angle_d   = r_d[DATA_WIDTH-1:0];
          quartor_d = {b1_q, take};
          ready_d   = 1'b1;
          busy_d    = 1'b0;
          state_d   = IDLE;
        end else begin
          j_d = j_q - JW'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst || rst_step) begin
      state_q   <= IDLE;
      r_q       <= '0;
      j_q       <= '0;
      b1_q      <= 1'b0;
      angle_q   <= '0;
      quartor_q <= '0;
      ready_q   <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      r_q       <= r_d;
      j_q       <= j_d;
      b1_q      <= b1_d;
      angle_q   <= angle_d;
      quartor_q <= quartor_d;
      ready_q   <= ready_d;
      busy_q    <= busy_d;
    end
  end

  assign angle_o    = angle_q;
  assign quartor    = quartor_q;
  assign data_ready = ready_q;
  assign busy       = busy_q;

endmodule

// File: tb/tb_angle_quartor_reducer.sv
// Self-checking bench for angle_quartor_reducer: cycle model based on
// floor-mod arithmetic, plus directed literal vectors and a random sweep.
module tb_angle_quartor_reducer;

  localparam int    J      = 8;
  localparam int    C0     = 102944;
  localparam int    TURN   = 4 * C0;
  localparam real   PI     = 3.14159265358979;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        rst_step = 1'b0;
  logic        new_data = 1'b0;
  logic [23:0] angle_i = '0;
  logic [19:0] angle_o;
  logic [1:0]  quartor;
  logic        data_ready;
  logic        busy;

  int n_checks = 0;
  int n_pass   = 0;
  bit chk_on   = 1'b0;

  // behavioural model state
  int m_cnt = 0, m_angle = 0, m_q = 0, m_pa = 0, m_pq = 0;
  bit m_busy = 1'b0, m_ready = 1'b0;

  angle_quartor_reducer #(
    .ANGLE_WIDTH(24),
    .DATA_WIDTH (20),
    .FRAC_BITS  (16)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .rst_step  (rst_step),
    .new_data  (new_data),
    .angle_i   (angle_i),
    .angle_o   (angle_o),
    .quartor   (quartor),
    .data_ready(data_ready),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  function automatic int ref_a(input int th);
    int m;
    m = th % TURN;
    if (m < 0) m += TURN;
    return m % C0;
  endfunction

  function automatic int ref_q(input int th);
    int m;
    m = th % TURN;
    if (m < 0) m += TURN;
    return m / C0;
  endfunction

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
  endtask

  // Cycle-level model: accept only when idle, result lands J+2 edges later
  always @(posedge clk) begin
    if (!rst || rst_step) begin
      m_cnt <= 0; m_busy <= 1'b0; m_ready <= 1'b0; m_angle <= 0; m_q <= 0;
    end else if (m_busy) begin
      m_cnt <= m_cnt - 1;
      if (m_cnt == 1) begin
        m_busy <= 1'b0; m_ready <= 1'b1; m_angle <= m_pa; m_q <= m_pq;
      end
    end else if (new_data) begin
      m_busy  <= 1'b1;
      m_ready <= 1'b0;
      m_cnt   <= J + 2;
      m_pa    <= ref_a($signed(angle_i));
      m_pq    <= ref_q($signed(angle_i));
    end
  end

  always @(negedge clk) begin
    if (chk_on) begin
      check("cyc_angle_o", int'(angle_o), m_angle);
      check("cyc_quartor", int'(quartor), m_q);
      check("cyc_data_ready", int'(data_ready), int'(m_ready));
      check("cyc_busy", int'(busy), int'(m_busy));
    end
  end

  task automatic start(input int a);
    @(negedge clk);
    new_data = 1'b1;
    angle_i  = 24'(a);
    @(negedge clk);
    new_data = 1'b0;
  endtask

  // Counts negedges after the accepting edge until data_ready; bounded
  task automatic wait_ready(input int already, output int cycles);
    cycles = already;
    while (!data_ready && cycles < 40) begin
      @(negedge clk);
      cycles++;
    end
  endtask

  task automatic run_vec(input string name, input int a, input int ea, input int eq);
    int cyc;
    start(a);
    check({name, "_ready_low"}, int'(data_ready), 0);
    wait_ready(0, cyc);
    check({name, "_latency"}, cyc, J + 2);
    check({name, "_angle"}, int'(angle_o), ea);
    check({name, "_quartor"}, int'(quartor), eq);
  endtask

  initial begin
    int cyc, a, ea, eq;
    real th, rc;
    bit ok;

    // reset
    repeat (2) @(negedge clk);
    check("rst_angle", int'(angle_o), 0);
    check("rst_quartor", int'(quartor), 0);
    check("rst_ready", int'(data_ready), 0);
    check("rst_busy", int'(busy), 0);
    rst = 1'b1;
    chk_on = 1'b1;

    // model pinned against hand-computed values
    check("pin_model_a", ref_a(-65536), 37408);
    check("pin_model_q", ref_q(-8388608), 2);

    run_vec("zero",   0,        0,     0);
    run_vec("halfpi", 102944,   0,     1);
    run_vec("neg1",   -65536,   37408, 3);
    run_vec("maxpos", 8388607,  50143, 1);
    run_vec("maxneg", -8388608, 52800, 2);
    run_vec("small",  5,        5,     0);

    // second strobe while busy must be ignored
    start(205888);
    repeat (2) @(negedge clk);
    new_data = 1'b1; angle_i = '0;
    @(negedge clk);
    new_data = 1'b0;
    wait_ready(3, cyc);
    check("busy_latency", cyc, J + 2);
    check("busy_angle", int'(angle_o), 0);
    check("busy_quartor", int'(quartor), 2);

    // abort mid-operation via rst_step
    start(205888);
    repeat (3) @(negedge clk);
    rst_step = 1'b1;
    @(negedge clk);
    rst_step = 1'b0;
    check("abort_angle", int'(angle_o), 0);
    check("abort_quartor", int'(quartor), 0);
    check("abort_busy", int'(busy), 0);
    ok = 1'b1;
    repeat (12) begin
      @(negedge clk);
      if (data_ready) ok = 1'b0;
    end
    check("abort_no_ready", int'(ok), 1);
    run_vec("after_abort", -65536, 37408, 3);

    // rst_step overrides a simultaneous new_data
    @(negedge clk);
    new_data = 1'b1; rst_step = 1'b1; angle_i = 24'(1000);
    @(negedge clk);
    new_data = 1'b0; rst_step = 1'b0;
    check("step_vs_new_busy", int'(busy), 0);

    // random sweep with back-to-back accepts
    for (int i = 0; i < 1000; i++) begin
      a  = $signed(24'($urandom));
      ea = ref_a(a);
      eq = ref_q(a);
      start(a);
      wait_ready(0, cyc);
      check("rnd_latency", cyc, J + 2);
      check("rnd_angle", int'(angle_o), ea);
      check("rnd_quartor", int'(quartor), eq);
      th = real'(a) / 65536.0;
      rc = real'(angle_o) / 65536.0 + real'(quartor) * PI / 2.0;
      ok = ($cos(th) - $cos(rc) < 1e-3) && ($cos(rc) - $cos(th) < 1e-3) &&
           ($sin(th) - $sin(rc) < 1e-3) && ($sin(rc) - $sin(th) < 1e-3);
      check("rnd_trig_recon", int'(ok), 1);
    end

    chk_on = 1'b0;
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
